multicycle_control_fsm: RTL

- Parametrised multicycle control unit: owns the control state register and the per-state control decode of the multicycle datapath.
- Adds behaviour the combinational decoder lacks: memory wait-state handshake, wait timeout, HALT and illegal-opcode fault trapping.
- Sits between the instruction register (opcode) and the datapath/memory control strobes; replaces the separate state-register + decode pair.

---
 rtl/multicycle_control_fsm_pkg.sv | 70 +++++++
 rtl/multicycle_control_fsm_if.sv | 29 ++
 rtl/multicycle_control_fsm_control_state_decode.sv | 95 +++++++++
 rtl/multicycle_control_fsm.sv | 104 ++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the multicycle control unit: state encoding,
// opcode class headers, datapath mux selects and fault cause codes.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    IMM3    = 4'd3,
    ALU_R3  = 4'd4,
    ALU_RI3 = 4'd5,
    ALU4    = 4'd6,
    BRANCH3 = 4'd7,
    MEM3    = 4'd8,
    LOAD4   = 4'd9,
    STORE4  = 4'd10,
    LOAD5   = 4'd11,
    JUMP3   = 4'd12,
    HALT    = 4'd13,
    FAULT   = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_R, CLS_ALU_RI, CLS_BRANCH, CLS_MEMREF,
    CLS_JUMP, CLS_IMM, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  localparam logic [1:0] HDR_ALU_R  = 2'b00;
  localparam logic [1:0] HDR_ALU_RI = 2'b01;
  localparam logic [2:0] HDR_BRANCH = 3'b100;
  localparam logic [2:0] HDR_MEMREF = 3'b101;
  localparam logic [5:0] OP_JUMP    = 6'b110000;
  localparam logic [5:0] OP_IMM     = 6'b110001;
  localparam logic [5:0] OP_HALT    = 6'b111111;

  localparam logic [1:0] RWD_MDR        = 2'd0;
  localparam logic [1:0] RWD_ALUOUT     = 2'd1;
  localparam logic [1:0] RWD_SE_IMM_BIG = 2'd2;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_BUSA = 1'b1;

  localparam logic [1:0] SRCB_FOUR         = 2'd0;
  localparam logic [1:0] SRCB_BUSB         = 2'd1;
  localparam logic [1:0] SRCB_SE_LS_OFFSET = 2'd2;
  localparam logic [1:0] SRCB_SE_OFFSET    = 2'd3;

  localparam logic [1:0] PC_ALUOUT       = 2'd0;
  localparam logic [1:0] PC_JUMP_ADDRESS = 2'd1;
  localparam logic [1:0] PC_ALU_DIRECT   = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam int ALU_ADD = 0;

  // Classifies on the six most significant opcode bits.
  function automatic op_class_t classify(input logic [5:0] top);
    if (top[5:4] == HDR_ALU_R)       return CLS_ALU_R;
    else if (top[5:4] == HDR_ALU_RI) return CLS_ALU_RI;
    else if (top[5:3] == HDR_BRANCH) return CLS_BRANCH;
    else if (top[5:3] == HDR_MEMREF) return CLS_MEMREF;
    else if (top == OP_JUMP)         return CLS_JUMP;
    else if (top == OP_IMM)          return CLS_IMM;
    else if (top == OP_HALT)         return CLS_HALT;
    else                             return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the control unit (master) and the datapath/memory side (slave).
interface multicycle_control_fsm_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pcWrite, pcWriteCond, memGetData, memRead, irWrite;
  logic                regWrite, aluSrcA, regTrackSelect;
  logic [1:0]          regWriteDataSelect, aluSrcB, pcSrc;
  logic [ALUOP_W-1:0]  aluOP;
  logic                halted, fault;
  logic [1:0]          fault_cause;
  logic [3:0]          state_o;

  modport master (
    input  opcode, mem_ready,
    output pcWrite, pcWriteCond, memGetData, memRead, irWrite, regWrite, aluSrcA,
           regTrackSelect, regWriteDataSelect, aluSrcB, pcSrc, aluOP,
           halted, fault, fault_cause, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pcWrite, pcWriteCond, memGetData, memRead, irWrite, regWrite, aluSrcA,
           regTrackSelect, regWriteDataSelect, aluSrcB, pcSrc, aluOP,
           halted, fault, fault_cause, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm_control_state_decode.sv
// Per-state control decode: registered state plus opcode to datapath strobes.
// Purely combinational; only FETCH's pcWrite/irWrite look at the ready input.
module control_state_decode
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4
) (
  input  state_t              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                ready,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic                memGetData,
  output logic                memRead,
  output logic                irWrite,
  output logic                regWrite,
  output logic                aluSrcA,
  output logic                regTrackSelect,
  output logic [1:0]          regWriteDataSelect,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          pcSrc,
  output logic [ALUOP_W-1:0]  aluOP
);
  op_class_t op_class;

  assign op_class       = classify(opcode[OPCODE_W-1 -: 6]);
  assign regTrackSelect = (op_class == CLS_BRANCH) ||
                          (op_class == CLS_MEMREF && opcode[OPCODE_W-4]);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    pcWrite            = 1'b0;
    pcWriteCond        = 1'b0;
    memGetData         = 1'b0;
    memRead            = 1'b0;
    irWrite            = 1'b0;
    regWrite           = 1'b0;
    aluSrcA            = SRCA_PC;
    regWriteDataSelect = RWD_MDR;
    aluSrcB            = SRCB_FOUR;
    pcSrc              = PC_ALUOUT;
    aluOP              = ALUOP_W'(ALU_ADD);
    unique case (state)
      FETCH: begin
        memRead = 1'b1;
        pcSrc   = PC_ALU_DIRECT;
        pcWrite = ready;
        irWrite = ready;
      end
      DECODE:  aluSrcB = SRCB_SE_LS_OFFSET;
      ALU_R3: begin
        aluSrcA = SRCA_BUSA;
        aluSrcB = SRCB_BUSB;
        aluOP   = opcode[ALUOP_W-1:0];
      end
      ALU_RI3: begin
        aluSrcA = SRCA_BUSA;
        aluSrcB = SRCB_SE_OFFSET;
        aluOP   = opcode[ALUOP_W-1:0];
      end
      ALU4: begin
        regWrite           = 1'b1;
        regWriteDataSelect = RWD_ALUOUT;
      end
      BRANCH3: begin
        pcWriteCond = 1'b1;
        aluSrcA     = SRCA_BUSA;
        aluSrcB     = SRCB_BUSB;
        aluOP       = {1'b1, opcode[ALUOP_W-2:0]};
      end
      MEM3: begin
        aluSrcA = SRCA_BUSA;
        aluSrcB = SRCB_SE_OFFSET;
      end
      LOAD4: begin
        memGetData = 1'b1;
        memRead    = 1'b1;
      end
      LOAD5:   regWrite = 1'b1;
      STORE4:  memGetData = 1'b1;
      JUMP3: begin
        pcWrite = 1'b1;
        pcSrc   = PC_JUMP_ADDRESS;
      end
      IMM3: begin
        regWrite           = 1'b1;
        regWriteDataSelect = RWD_SE_IMM_BIG;
      end
      // Trap states keep the memory in read mode so no write can leak out.
      HALT, FAULT: memRead = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: state register, memory wait/timeout tracking and
// sticky HALT/fault trapping; per-state strobes come from control_state_decode.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4,
  parameter bit MEM_WAIT = 1'b1,
  parameter int TIMEOUT  = 0
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_control_fsm_if.master bus
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic [1:0]       cause, cause_next;
  logic             ready, waiting, timeout;
  op_class_t        op_class;

  assign ready    = MEM_WAIT ? bus.mem_ready : 1'b1;
  assign op_class = classify(bus.opcode[OPCODE_W-1 -: 6]);
  assign waiting  = (state inside {FETCH, LOAD4, STORE4}) && !ready;
  // Fires on the TIMEOUT-th consecutive wait cycle; a ready in that cycle wins.
  assign timeout  = (TIMEOUT > 0) && waiting && (wait_cnt == CNT_LAST);

  always_comb begin
    state_next    = state;
    cause_next    = cause;
    wait_cnt_next = (waiting && !timeout) ? wait_cnt + 1'b1 : '0;
    unique case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (ready) state_next = DECODE;
      DECODE: begin
        unique case (op_class)
          CLS_ALU_R:  state_next = ALU_R3;
          CLS_ALU_RI: state_next = ALU_RI3;
          CLS_BRANCH: state_next = BRANCH3;
          CLS_MEMREF: state_next = MEM3;
          CLS_JUMP:   state_next = JUMP3;
          CLS_IMM:    state_next = IMM3;
          CLS_HALT:   state_next = HALT;
          default: begin
            state_next = FAULT;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      ALU_R3, ALU_RI3:             state_next = ALU4;
      MEM3:   state_next = bus.opcode[OPCODE_W-4] ? STORE4 : LOAD4;
      LOAD4:   if (ready) state_next = LOAD5;
      STORE4:  if (ready) state_next = FETCH;
      ALU4, BRANCH3, LOAD5, JUMP3, IMM3: state_next = FETCH;
      HALT, FAULT:                 state_next = state;
      default:                     state_next = IDLE;
    endcase
    if (timeout) begin
      state_next = FAULT;
      cause_next = CAUSE_TIMEOUT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      cause    <= CAUSE_NONE;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      cause    <= cause_next;
    end
  end

  assign bus.halted      = (state == HALT);
  assign bus.fault       = (state == FAULT);
  assign bus.fault_cause = cause;
  assign bus.state_o     = state;

  control_state_decode #(
    .OPCODE_W(OPCODE_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .state             (state),
    .opcode            (bus.opcode),
    .ready             (ready),
    .pcWrite           (bus.pcWrite),
    .pcWriteCond       (bus.pcWriteCond),
    .memGetData        (bus.memGetData),
    .memRead           (bus.memRead),
    .irWrite           (bus.irWrite),
    .regWrite          (bus.regWrite),
    .aluSrcA           (bus.aluSrcA),
    .regTrackSelect    (bus.regTrackSelect),
    .regWriteDataSelect(bus.regWriteDataSelect),
    .aluSrcB           (bus.aluSrcB),
    .pcSrc             (bus.pcSrc),
    .aluOP             (bus.aluOP)
  );
endmodule
